// File: rtl/cram_pkg.sv
// Shared types and default timing for the async/ADV-muxed CRAM controller.
// Holds the access-sequencer state encoding and pin-level constants.
// No logic lives here; it is imported by the top and the request latch.
package cram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR_SETUP,
        ST_WR_DATA,
        ST_WR_END,
        ST_RD_OE,
        ST_RD_WAIT,
        ST_RECOVER,
        ST_ACK
    } cram_state_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int DEF_NUM_CHIPS = 2;
    localparam int DEF_A_W       = 22;
    localparam int DEF_RD_WAIT   = 3;
    localparam int DEF_WR_WAIT   = 3;
    localparam int DEF_RECOVERY  = 1;

    // Wait/recovery counter width; comfortably covers the timing parameters.
    localparam int CNT_W = 8;

    // Chip-select index width, never narrower than one bit.
    function automatic int chip_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cram_async_controller_v2_req_latch.sv
// Select-edge detect, active request capture and one-deep pending request.
// Latency: start strobe is combinational from the edge or pending flag while idle.
// Backpressure: one pending slot; further edges while it is full are dropped.
module cram_req_latch
    import cram_pkg::*;
#(
    parameter int A_W    = 22,
    parameter int CHIP_W = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_select,
    input  logic [A_W+CHIP_W:0]   i_abus,
    input  logic [1:0]            i_be,
    input  logic [31:0]           i_dbus,
    input  logic                  i_32bit,
    input  logic                  i_rnw,
    input  logic                  i_idle,
    output logic                  o_start,
    output logic [CHIP_W-1:0]     o_chip,
    output logic [A_W-1:0]        o_addr,
    output logic [1:0]            o_be,
    output logic [31:0]           o_data,
    output logic                  o_32bit,
    output logic                  o_rnw
);

    localparam int REQ_W = CHIP_W + A_W + 2 + 32 + 2;

    logic             r_select_q;
    logic             r_pend_vld;
    logic [REQ_W-1:0] r_pend_req;
    logic [REQ_W-1:0] r_act_req;
    logic [REQ_W-1:0] w_bus_req;
    logic             w_rise;
    logic             w_unused_a0;

    // Byte-lane bit of the address has no meaning on a halfword bus.
    assign w_unused_a0 = i_abus[0];

    assign w_rise    = i_select & ~r_select_q;
    assign w_bus_req = {i_abus[A_W+CHIP_W:A_W+1], i_abus[A_W:1], i_be, i_dbus, i_32bit, i_rnw};
    assign o_start   = i_idle & (w_rise | r_pend_vld);
    assign {o_chip, o_addr, o_be, o_data, o_32bit, o_rnw} = r_act_req;

    // Edge detect, pending slot and active request; pending wins over a new edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_select_q <= LOW;
            r_pend_vld <= LOW;
            r_pend_req <= '0;
            r_act_req  <= '0;
        end else begin
            r_select_q <= i_select;
            if (i_idle) begin
                if (r_pend_vld) begin
                    r_act_req  <= r_pend_req;
                    r_pend_vld <= LOW;
                end else if (w_rise) begin
                    r_act_req  <= w_bus_req;
                end
            end else if (w_rise && !r_pend_vld) begin
                r_pend_req <= w_bus_req;
                r_pend_vld <= HIGH;
            end
        end
    end

endmodule

// File: rtl/cram_async_controller_v2.sv
// Async/ADV-muxed PSRAM controller: 16/32-bit OPB accesses as halfword pin cycles.
// Latency: 16b write WR_WAIT+4, 16b read RD_WAIT+3, 32b = both halves + RECOVERY.
// Backpressure: Sln_busy while active; one extra request is parked in a pending slot.
module cram_async_controller_v2
    import cram_pkg::*;
#(
    parameter int NUM_CHIPS = DEF_NUM_CHIPS,
    parameter int CHIP_W    = chip_bits(NUM_CHIPS),
    parameter int A_W       = DEF_A_W,
    parameter int RD_WAIT   = DEF_RD_WAIT,
    parameter int WR_WAIT   = DEF_WR_WAIT,
    parameter int RECOVERY  = DEF_RECOVERY
) (
    input  logic                  OPB_Clk,
    input  logic                  OPB_Rst,
    input  logic [A_W+CHIP_W:0]   OPB_ABus,
    input  logic [1:0]            OPB_BE,
    input  logic [31:0]           OPB_DBus,
    input  logic                  OPB_32Bit,
    input  logic                  OPB_RNW,
    input  logic                  OPB_select,
    output logic [31:0]           Sln_DBus,
    output logic                  Sln_xferAck,
    output logic                  Sln_busy,
    input  logic [15:0]           PSRAM_Mem_DQ_I,
    output logic [15:0]           PSRAM_Mem_DQ_O,
    output logic                  PSRAM_Mem_DQ_OE,
    output logic [A_W-1:0]        PSRAM_Mem_A,
    output logic [1:0]            PSRAM_Mem_BE,
    output logic                  PSRAM_Mem_WE,
    output logic                  PSRAM_Mem_OEN,
    output logic [NUM_CHIPS-1:0]  PSRAM_Mem_CEN,
    output logic                  PSRAM_Mem_ADV
);

    cram_state_t        r_state;
    cram_state_t        w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_half;
    logic [31:0]        r_dbus;

    logic               w_start;
    logic [CHIP_W-1:0]  w_chip;
    logic [A_W-1:0]     w_req_addr;
    logic [1:0]         w_req_be;
    logic [31:0]        w_req_data;
    logic               w_req_32;
    logic               w_req_rnw;

    logic [A_W-1:0]     w_addr;
    logic [15:0]        w_wdat;
    logic [1:0]         w_wbe;
    logic [NUM_CHIPS-1:0] w_cen_sel;
    logic               w_wr_done;
    logic               w_rd_done;
    logic               w_rec_done;

    cram_req_latch #(
        .A_W    (A_W),
        .CHIP_W (CHIP_W)
    ) u_req (
        .i_clk    (OPB_Clk),
        .i_rst    (OPB_Rst),
        .i_select (OPB_select),
        .i_abus   (OPB_ABus),
        .i_be     (OPB_BE),
        .i_dbus   (OPB_DBus),
        .i_32bit  (OPB_32Bit),
        .i_rnw    (OPB_RNW),
        .i_idle   (r_state == ST_IDLE),
        .o_start  (w_start),
        .o_chip   (w_chip),
        .o_addr   (w_req_addr),
        .o_be     (w_req_be),
        .o_data   (w_req_data),
        .o_32bit  (w_req_32),
        .o_rnw    (w_req_rnw)
    );

    // Second half of a 32-bit access targets the next halfword, wrapping inside the chip.
    assign w_addr     = r_half ? (w_req_addr + A_W'(1)) : w_req_addr;
    assign w_wdat     = r_half ? w_req_data[31:16] : w_req_data[15:0];
    assign w_wbe      = w_req_32 ? 2'b00 : ~w_req_be;
    assign w_cen_sel  = ~(NUM_CHIPS'(1) << w_chip);
    assign w_wr_done  = (r_cnt == CNT_W'(WR_WAIT));
    assign w_rd_done  = (r_cnt == CNT_W'(RD_WAIT));
    assign w_rec_done = (r_cnt == CNT_W'(RECOVERY - 1));
    assign Sln_DBus   = r_dbus;

    // State register.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Dwell counter, half select and read data capture.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_cnt  <= '0;
            r_half <= LOW;
            r_dbus <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (r_state == ST_IDLE)
                r_half <= LOW;
            else if (r_state == ST_RECOVER && w_next == ST_ADDR)
                r_half <= HIGH;
            if (r_state == ST_RD_WAIT && w_rd_done) begin
                if (r_half) r_dbus[31:16] <= PSRAM_Mem_DQ_I;
                else        r_dbus        <= {16'h0000, PSRAM_Mem_DQ_I};
            end
        end
    end

    // Next state and pin drive; every pin idles inactive unless the state claims it.
    always_comb begin
        w_next          = r_state;
        PSRAM_Mem_DQ_OE = HIGH;
        PSRAM_Mem_DQ_O  = '0;
        PSRAM_Mem_A     = '0;
        PSRAM_Mem_BE    = 2'b11;
        PSRAM_Mem_WE    = HIGH;
        PSRAM_Mem_OEN   = HIGH;
        PSRAM_Mem_ADV   = HIGH;
        PSRAM_Mem_CEN   = '1;
        Sln_xferAck     = LOW;
        Sln_busy        = LOW;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                PSRAM_Mem_ADV  = LOW;
                PSRAM_Mem_CEN  = w_cen_sel;
                PSRAM_Mem_A    = w_addr;
                PSRAM_Mem_DQ_O = 16'(w_addr);
                Sln_busy       = HIGH;
                w_next         = w_req_rnw ? ST_RD_OE : ST_WR_SETUP;
            end
            ST_WR_SETUP, ST_WR_DATA: begin
                PSRAM_Mem_CEN  = w_cen_sel;
                PSRAM_Mem_A    = w_addr;
                PSRAM_Mem_WE   = LOW;
                PSRAM_Mem_BE   = w_wbe;
                PSRAM_Mem_DQ_O = w_wdat;
                Sln_busy       = HIGH;
                if (r_state == ST_WR_SETUP) w_next = ST_WR_DATA;
                else if (w_wr_done)         w_next = ST_WR_END;
            end
            ST_WR_END: begin
                PSRAM_Mem_A = w_addr;
                Sln_busy    = HIGH;
                w_next      = (w_req_32 && !r_half) ? ST_RECOVER : ST_ACK;
            end
            ST_RD_OE, ST_RD_WAIT: begin
                PSRAM_Mem_CEN   = w_cen_sel;
                PSRAM_Mem_A     = w_addr;
                PSRAM_Mem_OEN   = LOW;
                PSRAM_Mem_DQ_OE = LOW;
                PSRAM_Mem_BE    = 2'b00;
                Sln_busy        = HIGH;
                if (r_state == ST_RD_OE) w_next = ST_RD_WAIT;
                else if (w_rd_done)      w_next = (w_req_32 && !r_half) ? ST_RECOVER : ST_ACK;
            end
            ST_RECOVER: begin
                Sln_busy = HIGH;
                if (w_rec_done) w_next = ST_ADDR;
            end
            ST_ACK: begin
                Sln_xferAck = HIGH;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cram_async_controller_v2.sv
module tb_cram_async_controller_v2;

    localparam int RD_WAIT  = 3;
    localparam int WR_WAIT  = 3;
    localparam int RECOVERY = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] abus;
    logic [1:0]  be;
    logic [31:0] dbus;
    logic        b32, rnw, sel;
    logic [31:0] s_dbus;
    logic        ack, busy;
    logic [15:0] dq_i, dq_o;
    logic        dq_oe;
    logic [21:0] a;
    logic [1:0]  mbe;
    logic        we, oen, adv;
    logic [1:0]  cen;

    always #5 clk = ~clk;

    cram_async_controller_v2 dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_32Bit(b32), .OPB_RNW(rnw), .OPB_select(sel),
        .Sln_DBus(s_dbus), .Sln_xferAck(ack), .Sln_busy(busy),
        .PSRAM_Mem_DQ_I(dq_i), .PSRAM_Mem_DQ_O(dq_o), .PSRAM_Mem_DQ_OE(dq_oe),
        .PSRAM_Mem_A(a), .PSRAM_Mem_BE(mbe), .PSRAM_Mem_WE(we), .PSRAM_Mem_OEN(oen),
        .PSRAM_Mem_CEN(cen), .PSRAM_Mem_ADV(adv)
    );

    // One expected pin snapshot per clock cycle.
    typedef struct {
        logic [1:0]  cen;
        logic [21:0] a;
        logic        chk_a;
        logic [15:0] dq_o;
        logic        chk_dq;
        logic        dq_oe, we, oen, adv;
        logic [1:0]  be;
        logic        ack, busy;
        logic [15:0] dq_in;
        logic        chk_dbus;
        logic [31:0] dbus;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_dbus = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ack_at = -1;
    int          ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t blank(input logic busy_v);
        exp_t r;
        r.cen = 2'b11; r.a = '0; r.chk_a = 1'b0; r.dq_o = '0; r.chk_dq = 1'b0;
        r.dq_oe = 1'b1; r.we = 1'b1; r.oen = 1'b1; r.adv = 1'b1; r.be = 2'b11;
        r.ack = 1'b0; r.busy = busy_v; r.dq_in = 16'hDEAD; r.chk_dbus = 1'b0; r.dbus = '0;
        return r;
    endfunction

    task automatic push_idle(input int n);
        exp_t r;
        r = blank(1'b0);
        r.chk_a = 1'b1; r.chk_dq = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(r);
    endtask

    // One halfword pin cycle: address phase, then the read or write phases.
    task automatic push_half(input logic [21:0] hw, input logic [1:0] mask, input logic rd,
                             input logic [1:0] bev, input logic [15:0] wd, input logic [15:0] rdv);
        exp_t r;
        r = blank(1'b1);
        r.cen = mask; r.adv = 1'b0; r.a = hw; r.chk_a = 1'b1; r.dq_o = hw[15:0]; r.chk_dq = 1'b1;
        exp_q.push_back(r);
        r = blank(1'b1);
        r.cen = mask;
        if (rd) begin
            r.oen = 1'b0; r.dq_oe = 1'b0; r.be = 2'b00;
            exp_q.push_back(r);
            for (int i = 0; i <= RD_WAIT; i++) begin
                r.dq_in = (i == RD_WAIT) ? rdv : 16'hDEAD;
                exp_q.push_back(r);
            end
        end else begin
            r.we = 1'b0; r.be = bev;
            exp_q.push_back(r);
            r.dq_o = wd; r.chk_dq = 1'b1;
            for (int i = 0; i <= WR_WAIT; i++) exp_q.push_back(r);
            exp_q.push_back(blank(1'b1));
        end
    endtask

    task automatic push_req(input logic [23:0] ab, input logic [1:0] bev_in, input logic [31:0] d,
                            input logic is32, input logic rd, input logic [15:0] lo, input logic [15:0] hi);
        logic [21:0] hw;
        logic [1:0]  mask;
        logic [1:0]  bev;
        exp_t        r;
        hw   = ab[22:1];
        mask = ab[23] ? 2'b01 : 2'b10;
        bev  = is32 ? 2'b00 : ~bev_in;
        push_half(hw, mask, rd, bev, d[15:0], lo);
        if (is32) begin
            for (int i = 0; i < RECOVERY; i++) exp_q.push_back(blank(1'b1));
            push_half(hw + 22'd1, mask, rd, bev, d[31:16], hi);
        end
        if (rd) model_dbus = is32 ? {hi, lo} : {16'h0000, lo};
        r = blank(1'b0);
        r.ack = 1'b1; r.chk_dbus = 1'b1; r.dbus = model_dbus;
        exp_q.push_back(r);
    endtask

    // Check one cycle against the model, then drive that cycle's bus inputs.
    task automatic step();
        exp_t r;
        @(negedge clk);
        cyc++;
        if (exp_q.size() == 0) begin
            chk("model_underrun", 32'd1, 32'd0);
            r = blank(1'b0);
        end else begin
            r = exp_q.pop_front();
        end
        chk("CEN", 32'(cen), 32'(r.cen));
        chk("WE", 32'(we), 32'(r.we));
        chk("OEN", 32'(oen), 32'(r.oen));
        chk("ADV", 32'(adv), 32'(r.adv));
        chk("DQ_OE", 32'(dq_oe), 32'(r.dq_oe));
        chk("MemBE", 32'(mbe), 32'(r.be));
        chk("xferAck", 32'(ack), 32'(r.ack));
        chk("busy", 32'(busy), 32'(r.busy));
        if (r.chk_a)    chk("A", 32'(a), 32'(r.a));
        if (r.chk_dq)   chk("DQ_O", 32'(dq_o), 32'(r.dq_o));
        if (r.chk_dbus) chk("Sln_DBus", s_dbus, r.dbus);
        if (ack) begin
            ack_cnt++;
            ack_at = cyc;
        end
        sel  = 1'b0;
        dq_i = r.dq_in;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic launch(input logic [23:0] ab, input logic [1:0] bv, input logic [31:0] d,
                          input logic is32, input logic rd);
        @(negedge clk);
        abus = ab; be = bv; dbus = d; b32 = is32; rnw = rd; sel = 1'b1;
        cyc = -1; ack_at = -1; ack_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; abus = '0; be = '0; dbus = '0; b32 = 1'b0; rnw = 1'b0; sel = 1'b0; dq_i = 16'hDEAD;
        #1;
        chk("rst_CEN", 32'(cen), 32'h3);
        chk("rst_ctl", 32'({we, oen, adv, dq_oe}), 32'hF);
        chk("rst_BE", 32'(mbe), 32'h3);
        chk("rst_A_DQ", 32'(a) | 32'(dq_o), 32'h0);
        chk("rst_sln", {s_dbus[30:0], ack} | 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 16-bit write, chip 0.
        push_req(24'h000010, 2'b01, 32'h0000BEEF, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("len_w16", exp_q.size(), 32'd8);
        push_idle(2);
        launch(24'h000010, 2'b01, 32'h0000BEEF, 1'b0, 1'b0);
        run(10);
        chk("lat_w16", ack_at, 32'd7);

        // 16-bit read, chip 1.
        push_req(24'h800004, 2'b11, 32'h0, 1'b0, 1'b1, 16'h1234, 16'h0);
        chk("len_r16", exp_q.size(), 32'd7);
        push_idle(2);
        launch(24'h800004, 2'b11, 32'h0, 1'b0, 1'b1);
        run(9);
        chk("lat_r16", ack_at, 32'd6);
        chk("dbus_r16", s_dbus, 32'h00001234);

        // 32-bit write across the top of chip 0.
        push_req(24'h7FFFFE, 2'b00, 32'hCAFEF00D, 1'b1, 1'b0, 16'h0, 16'h0);
        chk("len_w32", exp_q.size(), 32'd16);
        push_idle(2);
        launch(24'h7FFFFE, 2'b00, 32'hCAFEF00D, 1'b1, 1'b0);
        run(18);
        chk("lat_w32", ack_at, 32'd15);
        chk("dbus_hold", s_dbus, 32'h00001234);

        // 32-bit read.
        push_req(24'h000100, 2'b00, 32'h0, 1'b1, 1'b1, 16'h5678, 16'h9ABC);
        chk("len_r32", exp_q.size(), 32'd14);
        push_idle(2);
        launch(24'h000100, 2'b00, 32'h0, 1'b1, 1'b1);
        run(16);
        chk("lat_r32", ack_at, 32'd13);
        chk("dbus_r32", s_dbus, 32'h9ABC5678);

        // Back-to-back: B parks in pending, C arrives while pending is full and is lost.
        push_req(24'h000010, 2'b11, 32'h00001111, 1'b0, 1'b0, 16'h0, 16'h0);
        push_idle(1);
        push_req(24'h800006, 2'b11, 32'h0, 1'b0, 1'b1, 16'h4321, 16'h0);
        push_idle(4);
        launch(24'h000010, 2'b11, 32'h00001111, 1'b0, 1'b0);
        run(2);
        abus = 24'h800006; be = 2'b11; dbus = 32'h0; b32 = 1'b0; rnw = 1'b1; sel = 1'b1;
        run(2);
        abus = 24'h000020; be = 2'b11; dbus = 32'h00002222; b32 = 1'b0; rnw = 1'b0; sel = 1'b1;
        run(16);
        chk("b2b_acks", ack_cnt, 32'd2);
        chk("b2b_dbus", s_dbus, 32'h00004321);

        // Reset in the middle of a write: pins drop at once and no ack follows.
        push_req(24'h000010, 2'b01, 32'h0000BEEF, 1'b0, 1'b0, 16'h0, 16'h0);
        launch(24'h000010, 2'b01, 32'h0000BEEF, 1'b0, 1'b0);
        run(4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_CEN", 32'(cen), 32'h3);
        chk("mid_rst_ctl", 32'({we, oen, adv, dq_oe}), 32'hF);
        chk("mid_rst_BE", 32'(mbe), 32'h3);
        chk("mid_rst_A_DQ", 32'(a) | 32'(dq_o), 32'h0);
        chk("mid_rst_busy", 32'({busy, ack}), 32'h0);
        chk("mid_rst_dbus", s_dbus, 32'h0);
        exp_q.delete();
        model_dbus = '0;
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        push_idle(10);
        run(10);
        chk("mid_rst_noack", ack_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
